// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle RV32M multiply/divide sequencer beside the execute-stage ALU.
// Define QUINTA_DIV_EN to build in the restoring divider; without it, divide ops return 0.
module muldiv_ctrl #(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        req_ready,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef QUINTA_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t state;

    assign busy      = (state != S_IDLE);
    assign req_ready = ~busy;

    // Multiplier: 33-bit extended operands make one signed multiply cover all four variants.
    logic               mul_lo_q;
    logic signed [32:0] mul_a;
    logic signed [32:0] mul_b;
    logic signed [65:0] mul_prod;
    logic               mul_unused;
    logic               a_ext;
    logic               b_ext;

    assign a_ext      = (req_op[1:0] == 2'd1) || (req_op[1:0] == 2'd2);
    assign b_ext      = (req_op[1:0] == 2'd1);
    assign mul_prod   = mul_a * mul_b;
    assign mul_unused = ^mul_prod[65:64];

`ifdef QUINTA_DIV_EN
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic [31:0] div_dvs;
    logic [5:0]  div_cnt;
    logic        div_rem_sel;
    logic        div_neg;

    logic        req_signed;
    logic        req_sign_a;
    logic        req_sign_b;
    logic        req_div0;
    logic        req_ovf;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [31:0] quo_next;
    logic [31:0] rem_next;
    logic [31:0] div_mag;
    logic [31:0] div_result;

    assign req_signed = ~req_op[0];
    assign req_sign_a = req_signed & op_a[31];
    assign req_sign_b = req_signed & op_b[31];
    assign req_div0   = (op_b == 32'd0);
    assign req_ovf    = req_signed && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);

    // One restoring step: shift the next dividend bit into the partial remainder, subtract if it fits.
    assign div_shift  = {div_rem, div_quo[31]};
    assign div_diff   = div_shift - {1'b0, div_dvs};
    assign div_ge     = ~div_diff[32];
    assign rem_next   = div_ge ? div_diff[31:0] : div_shift[31:0];
    assign quo_next   = {div_quo[30:0], div_ge};
    assign div_mag    = div_rem_sel ? rem_next : quo_next;
    assign div_result = div_neg ? -div_mag : div_mag;
`else
    logic [5:0] div_iters_unused;
    assign div_iters_unused = 6'(DIV_ITERS);
`endif

    // NOTE: all state here is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are reset too, so resp_data reads 0 until the first result.
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            mul_lo_q   <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
`ifdef QUINTA_DIV_EN
            div_quo     <= '0;
            div_rem     <= '0;
            div_dvs     <= '0;
            div_cnt     <= '0;
            div_rem_sel <= 1'b0;
            div_neg     <= 1'b0;
`endif
        end else if (flush) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (!req_op[2]) begin
                            mul_lo_q <= (req_op[1:0] == 2'd0);
                            mul_a    <= {a_ext & op_a[31], op_a};
                            mul_b    <= {b_ext & op_b[31], op_b};
                            state    <= S_MUL;
                        end else begin
`ifdef QUINTA_DIV_EN
                            if (req_div0) begin
                                resp_data  <= req_op[1] ? op_a : 32'hFFFF_FFFF;
                                resp_valid <= 1'b1;
                                state      <= S_DONE;
                            end else if (req_ovf) begin
                                resp_data  <= req_op[1] ? 32'd0 : 32'h8000_0000;
                                resp_valid <= 1'b1;
                                state      <= S_DONE;
                            end else begin
                                div_quo     <= req_sign_a ? -op_a : op_a;
                                div_dvs     <= req_sign_b ? -op_b : op_b;
                                div_rem     <= '0;
                                div_cnt     <= 6'(DIV_ITERS - 1);
                                div_rem_sel <= req_op[1];
                                div_neg     <= req_op[1] ? req_sign_a : (req_sign_a ^ req_sign_b);
                                state       <= S_DIV;
                            end
`else
                            resp_data  <= '0;
                            resp_valid <= 1'b1;
                            state      <= S_DONE;
`endif
                        end
                    end
                end
                S_MUL: begin
                    resp_data  <= mul_lo_q ? mul_prod[31:0] : mul_prod[63:32];
                    resp_valid <= 1'b1;
                    state      <= S_DONE;
                end
`ifdef QUINTA_DIV_EN
                S_DIV: begin
                    div_quo <= quo_next;
                    div_rem <= rem_next;
                    if (div_cnt == 6'd0) begin
                        resp_data  <= div_result;
                        resp_valid <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        div_cnt <= div_cnt - 6'd1;
                    end
                end
`endif
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl; divide expectations follow QUINTA_DIV_EN.
module tb_muldiv_ctrl;

`ifdef QUINTA_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam int DIV_LAT = DIV_EN ? 33 : 1;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        flush = 1'b0;
    logic        req_ready;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_data;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] last_data = 32'd0;

    muldiv_ctrl #(.DIV_ITERS(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .op_a       (op_a),
        .op_b       (op_b),
        .flush      (flush),
        .req_ready  (req_ready),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_data  (resp_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] dv(input logic [31:0] v);
        return DIV_EN ? v : 32'd0;
    endfunction

    // Drives one request; returns 1 time unit into cycle T+1.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        op_a      = a;
        op_b      = b;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Waits for the strobe; lat=k means resp_valid seen in cycle T+k, 0 if it never came.
    task automatic wait_resp(output int lat, output logic [31:0] data,
                             output logic busy1, output logic busy_at);
        lat = 0; data = 32'd0; busy1 = 1'b0; busy_at = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) busy1 = busy;
            if (resp_valid) begin
                lat = k; data = resp_data; busy_at = busy;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int          lat;
        logic [31:0] data;
        logic        busy1;
        logic        busy_at;
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        issue(op, a, b);
        wait_resp(lat, data, busy1, busy_at);
        check({tag, " busy@T+1"}, 32'(busy1), 32'd1);
        check({tag, " busy@strobe"}, 32'(busy_at), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " data"}, data, exp);
        @(negedge clk);
        check({tag, " busy after"}, 32'(busy), 32'd0);
        check({tag, " single strobe"}, 32'(resp_valid), 32'd0);
        check({tag, " data hold"}, resp_data, exp);
        last_data = exp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        logic [31:0] data;
        logic        busy1;
        logic        busy_at;
        logic        seen;
        logic        busy_chk;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_data", resp_data, 32'd0);

        run_op("mul small",      OP_MUL,    32'h0000_1234, 32'h0000_5678, 32'h0626_0060, 2);
        run_op("mul -1*-1",      OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2);
        run_op("mulh -1*-1",     OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2);
        run_op("mulhsu -1*max",  OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        run_op("mulhu max*max",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        run_op("mulhsu min*2^31", OP_MULHSU, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 2);

        run_op("div -7/2",       OP_DIV,  32'hFFFF_FFF9, 32'd2, dv(32'hFFFF_FFFD), DIV_LAT);
        run_op("rem -7%2",       OP_REM,  32'hFFFF_FFF9, 32'd2, dv(32'hFFFF_FFFF), DIV_LAT);
        run_op("divu 100/7",     OP_DIVU, 32'd100, 32'd7, dv(32'd14), DIV_LAT);
        run_op("remu 100%7",     OP_REMU, 32'd100, 32'd7, dv(32'd2), DIV_LAT);
        run_op("div 7/-2",       OP_DIV,  32'd7, 32'hFFFF_FFFE, dv(32'hFFFF_FFFD), DIV_LAT);
        run_op("rem 7%-2",       OP_REM,  32'd7, 32'hFFFF_FFFE, dv(32'd1), DIV_LAT);
        run_op("divu min/max",   OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, dv(32'd0), DIV_LAT);
        run_op("remu max%16",    OP_REMU, 32'hFFFF_FFFF, 32'h10, dv(32'hF), DIV_LAT);

        run_op("divu by 0",      OP_DIVU, 32'd55, 32'd0, dv(32'hFFFF_FFFF), 1);
        run_op("div by 0",       OP_DIV,  32'd5, 32'd0, dv(32'hFFFF_FFFF), 1);
        run_op("remu by 0",      OP_REMU, 32'h1234_5678, 32'd0, dv(32'h1234_5678), 1);
        run_op("rem by 0",       OP_REM,  32'hFFFF_FFF9, 32'd0, dv(32'hFFFF_FFF9), 1);
        run_op("rem overflow",   OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, dv(32'd0), 1);
        run_op("div overflow",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, dv(32'h8000_0000), 1);

        // Flush a multiply while it is in the MUL state.
        issue(OP_MUL, 32'd3, 32'd5);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        seen = 1'b0; busy_chk = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
            if (k == 0) busy_chk = busy;
        end
        check("flush mul idle", 32'(busy_chk), 32'd0);
        check("flush mul no strobe", 32'(seen), 32'd0);
        check("flush mul data hold", resp_data, last_data);

        // Flush together with a request in IDLE: nothing accepted.
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_MUL; op_a = 32'd2; op_b = 32'd3; flush = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0; flush = 1'b0;
        seen = 1'b0;
        @(negedge clk);
        check("flush+req not accepted", 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        check("flush+req no strobe", 32'(seen), 32'd0);

        // Flush during DONE: the current strobe still leaves.
        issue(OP_DIVU, 32'd9, 32'd0);
        flush = 1'b1;
        @(negedge clk);
        check("flush in done strobe", 32'(resp_valid), 32'd1);
        check("flush in done data", resp_data, dv(32'hFFFF_FFFF));
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush in done after strobe", 32'(resp_valid), 32'd0);
        check("flush in done idle", 32'(busy), 32'd0);

        // Reset during a multiply.
        issue(OP_MUL, 32'd7, 32'd6);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0; busy_chk = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
            if (k == 0) busy_chk = busy;
        end
        check("rst mul idle", 32'(busy_chk), 32'd0);
        check("rst mul no strobe", 32'(seen), 32'd0);
        check("rst mul data cleared", resp_data, 32'd0);

`ifdef QUINTA_DIV_EN
        // Flush a divide at T+10, then a multiply accepted at T+11 answers at T+13.
        issue(OP_DIVU, 32'd100, 32'd7);
        seen = 1'b0;
        repeat (9) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(negedge clk);
        check("div busy at T+10", 32'(busy), 32'd1);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("div flushed idle T+11", 32'(busy), 32'd0);
        req_valid = 1'b1; req_op = OP_MUL; op_a = 32'h0000_1234; op_b = 32'h0000_5678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_resp(lat, data, busy1, busy_at);
        check("mul after flush latency", 32'(lat), 32'd2);
        check("mul after flush data", data, 32'h0626_0060);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        check("flushed div no strobe", 32'(seen), 32'd0);

        // Reset at T+5 of a divide.
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        check("rst div no strobe", 32'(seen), 32'd0);
        check("rst div idle", 32'(busy), 32'd0);
        check("rst div data cleared", resp_data, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide sequencer for the RV32M extension. It sits beside the single-cycle ALU in the execute stage. It accepts one M-extension operation at a time and runs either a registered two-stage multiplier or a 32-iteration restoring divider. It holds `busy` high so the pipeline stalls until `resp_valid` pulses with the 32-bit result.

## Interface
Parameters:
- `DIV_ITERS`, default 32. Number of divider iterations, equal to the operand width. The only legal value is 32.

Ports (reset is `rst`, synchronous, active-high; clock is `clk`):
- `clk`, in, 1. Clock, rising-edge.
- `rst`, in, 1. Synchronous active-high reset.
- `req_valid`, in, 1. Request present.
- `req_op`, in, 3. RISC-V funct3:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU
- `op_a`, in, 32. rs1 value.
- `op_b`, in, 32. rs2 value.
- `flush`, in, 1. Abort the in-flight operation. No response is produced.
- `req_ready`, out, 1. High only in IDLE.
- `busy`, out, 1. High when state is not IDLE. Drives the pipeline stall.
- `resp_valid`, out, 1. One-cycle result strobe.
- `resp_data`, out, 32. Result. Valid only while `resp_valid` is high.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Accept: `req_valid & req_ready & ~flush` at a rising edge. On accept, the op, operands and operand signs are latched.
- IDLE to MUL: any op 0–3.
- IDLE to DIV: ops 4–7 with `op_b != 0` and no signed overflow.
- IDLE to DONE: divide-by-zero or signed overflow. The result is computed directly.
- MUL:
  - Computes a 66-bit product of two 33-bit sign/zero-extended operands.
  - MULH and MULHSU sign-extend `op_a`. Only MULH sign-extends `op_b`.
  - The product is registered, then the state goes to DONE.
  - MUL returns `product[31:0]`. The others return `product[63:32]`.
- DIV:
  - Restoring divide on magnitudes. Signed ops negate negative operands at accept.
  - One quotient bit per cycle, with a 6-bit down-counter from 31 to 0.
  - When the counter reaches 0, the state goes to DONE.
  - Quotient is negated if `sign_a ^ sign_b` (DIV only).
  - Remainder is negated if `sign_a` (REM only).
- Divide-by-zero:
  - DIV/DIVU return 0xFFFFFFFF.
  - REM/REMU return `op_a`.
- Signed overflow (DIV/REM with `op_a=0x80000000`, `op_b=0xFFFFFFFF`):
  - DIV returns 0x80000000.
  - REM returns 0.
- DONE: `resp_valid=1` for exactly one cycle, then IDLE. No backpressure; the consumer must take it.
- `flush` in any state: next state is IDLE. Any `resp_valid` the next cycle is suppressed. Flush in DONE still lets the current-cycle strobe out.
- `flush` together with `req_valid` in IDLE: nothing is accepted.
- Requests are never accepted in DONE. Back-to-back operations therefore have at least one idle cycle between strobes.

## Timing
- Reset values:
  - state IDLE
  - `req_ready=1`, `busy=0`, `resp_valid=0`, `resp_data=0`
  - counter 0
  - all operand and product registers 0
- Reset mid-operation aborts the operation. No response follows.
- Accept edge ends cycle T.
- MUL ops: MUL state in T+1, `resp_valid` in T+2. Latency 2.
- Divide, normal: DIV state in T+1..T+32, `resp_valid` in T+33. Latency 33.
- Divide-by-zero or overflow: `resp_valid` in T+1. Latency 1.
- `busy` rises in T+1 and falls in the cycle after DONE.
- `req_ready` is the combinational inverse of `busy`.
- `resp_data` is registered. It holds its last value outside DONE.

## Configuration
- `QUINTA_DIV_EN` defined:
  - The divider is compiled in as described above.
- `QUINTA_DIV_EN` undefined:
  - The divider datapath and DIV state are removed.
  - Ops 4–7 go IDLE to DONE and return 0 at T+1.
  - MUL ops are unchanged.

## Test plan
- MUL, a=0x00001234, b=0x00005678 → `resp_data`=0x06260060 at T+2, `busy` high in T+1..T+2.
- MULH, a=0xFFFFFFFF (-1), b=0xFFFFFFFF → 0x00000000.
- MULHSU, same operands → 0xFFFFFFFF.
- MULHU, same operands → 0xFFFFFFFE.
- DIV, a=-7 (0xFFFFFFF9), b=2 → 0xFFFFFFFD at T+33.
- REM, same operands → 0xFFFFFFFF.
- DIVU, a=100, b=7 → 14.
- REMU, a=100, b=7 → 2.
- DIVU, b=0 → 0xFFFFFFFF at T+1.
- REM, a=0x80000000, b=0xFFFFFFFF → 0 at T+1.
- DIV, same operands → 0x80000000.
- DIV in flight, `flush` at T+10 → IDLE at T+11, no `resp_valid` ever.
- New MUL accepted at T+11 → result at T+13.
- `rst` at T+5 of DIV → `resp_valid` stays 0.
- Build without `QUINTA_DIV_EN`: DIVU 100/7 → 0 at T+1, while MUL still gives correct results.
